// File: rtl/maze_path_replayer.sv
// maze_path_replayer
// Drains the 2-bit move stack into a local path buffer, then replays the
// moves oldest-first on a valid/ready stream with the running (x, y) cell.
// Build option: define MAZE_PATH_REPLAYER_COORD_EN to include the cursor;
// without it out_x/out_y are tied to 0 and everything else is unchanged.
module maze_path_replayer #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stk_empty,
    input  logic [1:0]               stk_data,
    output logic                     stk_pop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_dir,
    output logic [COORD_W-1:0]       out_x,
    output logic [COORD_W-1:0]       out_y,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   path_len,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_CAPTURE,
        ST_REPLAY,
        ST_DONE
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         dir_q;
    logic               valid_q;
    logic               last_q;
    logic               ovf_q;
    logic               done_q;
    logic [1:0]         path_q [DEPTH];

    logic               full_d;
    logic               hs_d;
    logic [IDX_W-1:0]   rd_idx_d;

    assign full_d   = (len_q == LEN_W'(DEPTH));
    assign hs_d     = valid_q & out_ready;
    assign rd_idx_d = IDX_W'(len_q - LEN_W'(1));

    // The pop decision depends on this cycle's stk_empty, so stk_pop is
    // decoded from the state register rather than held in its own flop.
    assign stk_pop   = (state_q == ST_POP) & ~stk_empty & ~full_d;
    assign out_valid = valid_q;
    assign out_dir   = dir_q;
    assign out_last  = last_q;
    assign path_len  = len_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    // Path buffer: captures the popped move; contents need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_CAPTURE) begin
            path_q[len_q[IDX_W-1:0]] <= stk_data;
        end
    end

    // Control FSM: drain the stack, then replay the buffer newest-index-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            dir_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (stk_empty && (len_q == '0)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (stk_empty || full_d) begin
                        // Full with moves still stacked means the path was cut short.
                        if (!stk_empty) begin
                            ovf_q <= 1'b1;
                        end
                        idx_q   <= rd_idx_d;
                        dir_q   <= path_q[rd_idx_d];
                        valid_q <= 1'b1;
                        last_q  <= (len_q == LEN_W'(1));
                        state_q <= ST_REPLAY;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    len_q   <= len_q + LEN_W'(1);
                    state_q <= ST_POP;
                end
                ST_REPLAY: begin
                    if (hs_d) begin
                        if (idx_q == '0) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q  <= idx_q - IDX_W'(1);
                            dir_q  <= path_q[idx_q - IDX_W'(1)];
                            last_q <= (idx_q == IDX_W'(1));
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MAZE_PATH_REPLAYER_COORD_EN
    logic [COORD_W-1:0] cur_x_q;
    logic [COORD_W-1:0] cur_y_q;
    logic [COORD_W-1:0] step_x_d;
    logic [COORD_W-1:0] step_y_d;

    // Post-move cell: cursor plus the currently presented move, wrapping.
    always_comb begin
        step_x_d = cur_x_q;
        step_y_d = cur_y_q;
        case (dir_q)
            2'b00:   step_y_d = cur_y_q - COORD_W'(1);
            2'b01:   step_x_d = cur_x_q + COORD_W'(1);
            2'b10:   step_y_d = cur_y_q + COORD_W'(1);
            default: step_x_d = cur_x_q - COORD_W'(1);
        endcase
    end

    // Cursor: reloaded on start, advanced on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_q <= COORD_W'(START_X);
            cur_y_q <= COORD_W'(START_Y);
        end else if ((state_q == ST_IDLE) && start) begin
            cur_x_q <= COORD_W'(START_X);
            cur_y_q <= COORD_W'(START_Y);
        end else if ((state_q == ST_REPLAY) && hs_d) begin
            cur_x_q <= step_x_d;
            cur_y_q <= step_y_d;
        end
    end

    assign out_x = step_x_d;
    assign out_y = step_y_d;
`else
    logic unused_start;
    assign unused_start = (START_X != 0) ^ (START_Y != 0);
    assign out_x = '0;
    assign out_y = '0;
`endif

endmodule

// File: tb/tb_maze_path_replayer.sv
// Bench for maze_path_replayer: stack model feeding the DUT, expected beats
// derived from the push list (oldest surviving push first, wrapped coords).
module tb_maze_path_replayer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned START_X = 0;
    localparam int unsigned START_Y = 0;
    localparam int unsigned LEN_W   = $clog2(DEPTH) + 1;
    localparam int          MASK    = (1 << COORD_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stk_empty;
    logic [1:0]         stk_data;
    logic               stk_pop;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_dir;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic               out_last;
    logic [LEN_W-1:0]   path_len;
    logic               overflow;
    logic               busy;
    logic               done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    maze_path_replayer #(
        .DEPTH  (DEPTH),
        .COORD_W(COORD_W),
        .START_X(START_X),
        .START_Y(START_Y)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stk_empty(stk_empty),
        .stk_data (stk_data),
        .stk_pop  (stk_pop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dir  (out_dir),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_last (out_last),
        .path_len (path_len),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    // Stack model: stk_mem[0] is the first push, top is stk_mem[load_cnt-pops-1].
    logic [1:0] stk_mem [64];
    int         load_cnt = 0;
    int         pops = 0;
    logic       stk_clr;

    assign stk_empty = (load_cnt <= pops);

    always @(posedge clk) begin
        if (stk_clr) begin
            pops <= 0;
        end else if (stk_pop) begin
            if (pops < load_cnt) stk_data <= stk_mem[load_cnt - pops - 1];
            pops <= pops + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_reset(input string tag);
        int ex_x;
        int ex_y;
`ifdef MAZE_PATH_REPLAYER_COORD_EN
        ex_x = START_X & MASK;
        ex_y = (START_Y - 1) & MASK;
`else
        ex_x = 0;
        ex_y = 0;
`endif
        chk({tag, ":stk_pop"},   stk_pop,   0);
        chk({tag, ":out_valid"}, out_valid, 0);
        chk({tag, ":out_last"},  out_last,  0);
        chk({tag, ":done"},      done,      0);
        chk({tag, ":busy"},      busy,      0);
        chk({tag, ":overflow"},  overflow,  0);
        chk({tag, ":path_len"},  path_len,  0);
        chk({tag, ":out_dir"},   out_dir,   0);
        chk({tag, ":out_x"},     out_x,     ex_x);
        chk({tag, ":out_y"},     out_y,     ex_y);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) stk_mem[i] = 2'($urandom_range(0, 3));
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic run_case(input string name, input int n_push, input int mode);
        int ex_dir [64];
        int ex_x [64];
        int ex_y [64];
        int n_exp, base, x, y, k, cyc, first_v, done_c, done_n, last_hs;
        n_exp = (n_push > int'(DEPTH)) ? int'(DEPTH) : n_push;
        base  = n_push - n_exp;
        x = START_X;
        y = START_Y;
        for (int i = 0; i < n_exp; i++) begin
            ex_dir[i] = int'(stk_mem[base + i]);
            case (ex_dir[i])
                0:       y = (y - 1) & MASK;
                1:       x = (x + 1) & MASK;
                2:       y = (y + 1) & MASK;
                default: x = (x - 1) & MASK;
            endcase
`ifdef MAZE_PATH_REPLAYER_COORD_EN
            ex_x[i] = x;
            ex_y[i] = y;
`else
            ex_x[i] = 0;
            ex_y[i] = 0;
`endif
        end

        load_cnt = n_push;
        stk_clr  = 1'b1;
        @(posedge clk); #1;
        stk_clr = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        cyc = 1; k = 0; first_v = -1; done_c = -1; done_n = 0; last_hs = -1;
        while (cyc < 400 && !(done_n > 0 && cyc > done_c + 1)) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (cyc == 1) chk({name, ":busy"}, busy, 1);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (k < n_exp) begin
                    chk({name, ":dir"},  out_dir,  ex_dir[k]);
                    chk({name, ":x"},    out_x,    ex_x[k]);
                    chk({name, ":y"},    out_y,    ex_y[k]);
                    chk({name, ":last"}, out_last, (k == n_exp - 1));
                end else begin
                    chk({name, ":extra_beat"}, k, n_exp);
                end
                if (out_ready) begin
                    k++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                done_n++;
                done_c = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;

        chk({name, ":beats"},     k,        n_exp);
        chk({name, ":path_len"},  path_len, n_exp);
        chk({name, ":overflow"},  overflow, (n_push > int'(DEPTH)));
        chk({name, ":done_cnt"},  done_n,   1);
        chk({name, ":remaining"}, load_cnt - pops, n_push - n_exp);
        chk({name, ":busy_end"},  busy,     0);
        if (n_exp > 0) begin
            chk({name, ":first_valid_cyc"}, first_v, 2 * n_exp + 2);
            chk({name, ":done_cyc"},        done_c,  last_hs + 1);
        end else begin
            chk({name, ":no_valid"}, first_v, -1);
            chk({name, ":done_cyc"}, done_c,  2);
        end
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        stk_clr   = 1'b1;
        #3;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three-move path: pushes 01,01,10 with 10 on top.
        stk_mem[0] = 2'b01; stk_mem[1] = 2'b01; stk_mem[2] = 2'b10;
        run_case("path3", 3, 0);
        run_case("empty", 0, 0);
        stk_mem[0] = 2'b01; stk_mem[1] = 2'b01; stk_mem[2] = 2'b10;
        run_case("path3_stall", 3, 1);
        stk_mem[0] = 2'b11; stk_mem[1] = 2'b01;
        run_case("wrap", 2, 0);
        fill_random(DEPTH + 3);
        run_case("overflow", DEPTH + 3, 0);
        fill_random(DEPTH);
        run_case("full_exact", DEPTH, 2);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, DEPTH + 4);
            fill_random(n);
            run_case("random", n, $urandom_range(0, 2));
        end

        // Reset during replay after one accepted beat.
        stk_mem[0] = 2'b01; stk_mem[1] = 2'b01; stk_mem[2] = 2'b10;
        load_cnt = 3;
        stk_clr  = 1'b1;
        @(posedge clk); #1;
        stk_clr   = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else @(posedge clk);
        end
        chk("midrst:reach_replay", seen, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fill_random(5);
        run_case("after_rst", 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/maze_path_replayer.md
# maze_path_replayer

Downstream consumer of the 2-bit move stack in the maze datapath. After the explorer finishes, this block drains every stored move from the stack into a local buffer. Because the stack is LIFO, the block then replays the moves in reverse pop order, so the path runs start-to-goal. Each move is emitted on a valid/ready stream together with the running (x, y) cell coordinate.

## Interface
- DEPTH, 256: path buffer entries; must be ≥ stack depth
- COORD_W, 4: width of each coordinate
- START_X, 0: x coordinate of the start cell
- START_Y, 0: y coordinate of the start cell
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse in IDLE; begins drain; ignored in all other states
- stk_empty  in  1  stack empty flag
- stk_data  in  2  stack read data; valid the cycle after stk_pop
- stk_pop  out  1  one-cycle pop request to the stack
- out_valid  out  1  replay beat valid
- out_ready  in  1  downstream accepts beat
- out_dir  out  2  move code: 00 up, 01 right, 10 down, 11 left
- out_x  out  COORD_W  x coordinate after applying out_dir
- out_y  out  COORD_W  y coordinate after applying out_dir
- out_last  out  1  marks the final beat
- path_len  out  $clog2(DEPTH)+1  moves captured in the current run
- overflow  out  1  sticky; buffer filled while stack not empty
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on run completion

## Operation
- FSM states: IDLE, POP, CAPTURE, REPLAY, DONE.
- **IDLE**
  - start=1 → clear path_len and overflow; load cursor (x, y) = (START_X, START_Y); go to POP.
- **POP**
  - If stk_empty=1 and path_len=0 → DONE. No beats are emitted.
  - If stk_empty=1 and path_len>0 → REPLAY, with read index = path_len−1.
  - If path_len=DEPTH and stk_empty=0 → set overflow; go to REPLAY.
  - Otherwise assert stk_pop for this cycle only; go to CAPTURE.
- **CAPTURE**
  - buf[path_len] ← stk_data; path_len += 1; return to POP.
- **REPLAY**
  - out_dir = buf[index]; out_valid=1.
  - On handshake (out_valid & out_ready):
    - cursor is updated per the move rules below;
    - if index=0 → DONE; else index −= 1.
  - out_x/out_y are combinational from cursor + out_dir, so they show the post-move cell.
  - out_last=1 when index=0.
- **DONE**
  - done=1 for one cycle; go to IDLE. path_len and overflow hold until the next start.
- Move rules, applied modulo 2^COORD_W (wrap, no saturation):
  - up: y−1
  - right: x+1
  - down: y+1
  - left: x−1
- out_valid, out_dir and out_x/out_y must stay stable while out_valid=1 and out_ready=0.
- The block never asserts stk_pop outside POP.

## Timing
- Reset values:
  - state IDLE
  - stk_pop, out_valid, out_last, done, busy, overflow all 0
  - path_len 0; out_dir 00
  - cursor = (START_X, START_Y)
- Reset mid-run aborts immediately. No done pulse; the buffer contents become don't-care.
- Drain costs 2 cycles per move: POP then CAPTURE. Start to first out_valid = 2N+2 cycles for N moves (start edge → POP; N×(POP,CAPTURE); final POP → REPLAY).
- Replay with out_ready held at 1: one beat per cycle; done is asserted the cycle after the last beat.
- Empty stack at start: done is asserted 2 cycles after start; out_valid is never asserted.

## Configuration
- MAZE_PATH_REPLAYER_COORD_EN defined:
  - cursor registers and adders are present;
  - out_x/out_y behave as specified.
- Undefined:
  - cursor logic is removed;
  - out_x/out_y are tied to 0;
  - all other behaviour (handshake, order, timing, done) is identical.

## Test plan
- Stack holds pushes 01,01,10 (top=10); start, out_ready=1 → three pops. Beats are (01,x=1,y=0), (01,2,0), (10,2,1); out_last on the third beat; path_len=3; done one cycle later.
- Empty stack; start → no stk_pop, no out_valid; done exactly 2 cycles after start; path_len=0.
- Same 3-move path with out_ready toggling 1,0,0,1,… → outputs held stable while stalled; the same beat sequence is delivered with no drops or duplicates.
- START_X=0, first move 11 (left) → out_x=15 (COORD_W=4 wrap); a following move 01 → out_x=0.
- DEPTH=4, stack with 6 entries → exactly 4 pops; overflow=1; 4 beats replayed; 2 entries remain in the stack.
- rst asserted during REPLAY after 1 beat → all outputs at reset values the same cycle; a fresh start with a reloaded stack replays correctly from START_X/START_Y.
